// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader is the slave; the upstream byte source / memory side is the master.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: LE word count header, then N LE words written to instruction memory.
// Holds the CPU in reset until the image is complete.
//
// state  | meaning
// S_HDR  | collecting the 4-byte word count
// S_DATA | assembling and writing instruction words
// S_DONE | image complete, CPU released, input stalled
// S_ERR  | header count exceeds memory capacity, CPU held, input stalled
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    imem_loader_if.slave      bus,
    input  logic              restart,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    typedef enum logic [1:0] {S_HDR, S_DATA, S_DONE, S_ERR} state_t;

    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_W;

    state_t            state, state_nxt;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       n_words;
    logic [23:0]       word_lo;
    logic              rdy;
    logic              accept;
    logic              last_byte;
    logic [31:0]       n_full;

    assign rdy            = (state == S_HDR || state == S_DATA) && !rst;
    assign bus.byte_ready = rdy;
    // restart wins over a byte offered in the same cycle
    assign accept         = bus.byte_valid && rdy && !restart;
    assign last_byte      = accept && (byte_cnt == 2'd3);
    assign n_full         = {bus.byte_data, n_words[23:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_HDR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cpu_rst   = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state)
            S_HDR: begin
                if (last_byte) begin
                    if (n_full == 32'd0)                state_nxt = S_DONE;
                    else if ({1'b0, n_full} > CAPACITY) state_nxt = S_ERR;
                    else                                state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                // words_loaded already counts the word being written during the pulse
                if (bus.imem_we && n_words == 32'(words_loaded)) state_nxt = S_DONE;
            end
            S_DONE: begin
                cpu_rst   = 1'b0;
                load_done = 1'b1;
            end
            S_ERR: begin
                load_err  = 1'b1;
            end
            default: state_nxt = S_HDR;
        endcase
        if (restart) state_nxt = S_HDR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt       <= '0;
            word_idx       <= '0;
            n_words        <= '0;
            word_lo        <= '0;
            words_loaded   <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            if (restart) begin
                byte_cnt     <= '0;
                word_idx     <= '0;
                n_words      <= '0;
                words_loaded <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (state == S_HDR) begin
                    n_words[{byte_cnt, 3'b000} +: 8] <= bus.byte_data;
                    if (last_byte) word_idx <= '0;
                end else if (!last_byte) begin
                    word_lo[{byte_cnt, 3'b000} +: 8] <= bus.byte_data;
                end else begin
                    bus.imem_we    <= 1'b1;
                    bus.imem_addr  <= word_idx;
                    bus.imem_wdata <= {bus.byte_data, word_lo};
                    word_idx       <= word_idx + 1'b1;
                    words_loaded   <= words_loaded + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header handling, word writes, restart and async reset.
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic            clk;
    logic            rst;
    logic            restart;
    logic            cpu_rst;
    logic            load_done;
    logic            load_err;
    logic [ADDR_W:0] words_loaded;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .restart      (restart),
        .cpu_rst      (cpu_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log; a pulse must never overlap CPU release
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            checks++;
            if (cpu_rst !== 1'b1 || load_done !== 1'b0) begin
                failures++;
                $display("FAIL we_overlap: cpu_rst=%b load_done=%b required 1/0", cpu_rst, load_done);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.byte_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte_ready=%b required 1", bus.byte_ready);
        end else begin
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        restart = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (load_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (load_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout: load_done=%b required 1", name, load_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        restart = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        @(negedge clk);
        checks++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_wr: we=%b addr=%h data=%h required 0", bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
        checks++;
        if ({cpu_rst, load_done, load_err, bus.byte_ready} !== 4'b1000 || words_loaded !== '0) begin
            failures++;
            $display("FAIL reset_ctl: cpu_rst/done/err/ready=%b%b%b%b words=%0d required 1000/0",
                     cpu_rst, load_done, load_err, bus.byte_ready, words_loaded);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: byte_ready=%b required 1", bus.byte_ready);
        end
    endtask

    task automatic test_two_words();
        int c0;
        do_reset();
        c0 = cyc;
        send_word(32'd2);
        send_word(32'h00100513);
        send_word(32'h00200593);
        checks++;
        if (cyc - c0 != 12) begin
            failures++;
            $display("FAIL b2b_cycles: got %0d required 12", cyc - c0);
        end
        checks++;
        if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'd1 || bus.imem_wdata !== 32'h00200593 ||
            cpu_rst !== 1'b1 || words_loaded !== 9'd2) begin
            failures++;
            $display("FAIL two_last_pulse: we=%b addr=%h data=%h cpu_rst=%b words=%0d required 1/01/00200593/1/2",
                     bus.imem_we, bus.imem_addr, bus.imem_wdata, cpu_rst, words_loaded);
        end
        @(negedge clk);
        checks++;
        if (bus.imem_we !== 1'b0 || cpu_rst !== 1'b0 || load_done !== 1'b1 || bus.byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL two_release: we=%b cpu_rst=%b done=%b ready=%b required 0/0/1/0",
                     bus.imem_we, cpu_rst, load_done, bus.byte_ready);
        end
        checks++;
        if (wr_addr.size() != 2) begin
            failures++;
            $display("FAIL two_count: got %0d writes required 2", wr_addr.size());
        end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00100513) begin
            failures++;
            $display("FAIL two_word0: addr=%h data=%h required 00/00100513", wr_addr[0], wr_data[0]);
        end
        // imem_addr/imem_wdata hold after the pulse
        checks++;
        if (bus.imem_addr !== 8'd1 || bus.imem_wdata !== 32'h00200593) begin
            failures++;
            $display("FAIL two_hold: addr=%h data=%h required 01/00200593", bus.imem_addr, bus.imem_wdata);
        end
    endtask

    task automatic test_zero_header();
        do_reset();
        send_word(32'd0);
        checks++;
        if (cpu_rst !== 1'b0 || load_done !== 1'b1 || bus.byte_ready !== 1'b0 || load_err !== 1'b0) begin
            failures++;
            $display("FAIL zero_state: cpu_rst=%b done=%b ready=%b err=%b required 0/1/0/0",
                     cpu_rst, load_done, bus.byte_ready, load_err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr.size() != 0 || words_loaded !== '0) begin
            failures++;
            $display("FAIL zero_writes: got %0d writes words=%0d required 0/0", wr_addr.size(), words_loaded);
        end
    endtask

    task automatic test_overflow_header();
        do_reset();
        send_word(32'h00000101);
        checks++;
        if (load_err !== 1'b1 || cpu_rst !== 1'b1 || bus.byte_ready !== 1'b0 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL ovf_state: err=%b cpu_rst=%b ready=%b done=%b required 1/1/0/0",
                     load_err, cpu_rst, bus.byte_ready, load_done);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h55;
        repeat (4) @(negedge clk);
        bus.byte_valid = 1'b0;
        checks++;
        if (load_err !== 1'b1 || wr_addr.size() != 0 || words_loaded !== '0) begin
            failures++;
            $display("FAIL ovf_sticky: err=%b writes=%0d words=%0d required 1/0/0",
                     load_err, wr_addr.size(), words_loaded);
        end
    endtask

    task automatic test_random_valid();
        logic [7:0] img [8];
        int ready_seen;
        img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8 && $urandom_range(0, 1) == 0; k++) begin
                bus.byte_data = $urandom_range(0, 255);
                @(negedge clk);
            end
            send_byte(img[i]);
        end
        wait_done("rand");
        checks++;
        if (wr_addr.size() != 1) begin
            failures++;
            $display("FAIL rand_count: got %0d writes required 1", wr_addr.size());
        end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rand_word: addr=%h data=%h required 00/deadbeef", wr_addr[0], wr_data[0]);
        end
        ready_seen = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            if (bus.byte_ready !== 1'b0) ready_seen++;
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        checks++;
        if (ready_seen != 0 || wr_addr.size() != 1 || words_loaded !== 9'd1 || load_done !== 1'b1) begin
            failures++;
            $display("FAIL rand_after_done: ready_cycles=%0d writes=%0d words=%0d done=%b required 0/1/1/1",
                     ready_seen, wr_addr.size(), words_loaded, load_done);
        end
    endtask

    task automatic test_restart();
        do_reset();
        send_word(32'd3);
        send_word(32'h44332211);
        send_byte(8'hAA);
        send_byte(8'hBB);
        checks++;
        if (wr_addr.size() != 1 || wr_data[0] !== 32'h44332211) begin
            failures++;
            $display("FAIL rst_pre_word: writes=%0d required 1 with 44332211", wr_addr.size());
        end
        restart = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hCC;
        @(negedge clk);
        restart = 1'b0;
        bus.byte_valid = 1'b0;
        checks++;
        if (cpu_rst !== 1'b1 || words_loaded !== '0 || load_done !== 1'b0 || bus.imem_we !== 1'b0) begin
            failures++;
            $display("FAIL restart_state: cpu_rst=%b words=%0d done=%b we=%b required 1/0/0/0",
                     cpu_rst, words_loaded, load_done, bus.imem_we);
        end
        wr_addr.delete();
        wr_data.delete();
        send_word(32'd1);
        send_word(32'h00000013);
        wait_done("restart");
        checks++;
        if (wr_addr.size() != 1) begin
            failures++;
            $display("FAIL restart_count: got %0d writes required 1", wr_addr.size());
        end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00000013) begin
            failures++;
            $display("FAIL restart_word: addr=%h data=%h required 00/00000013", wr_addr[0], wr_data[0]);
        end
        checks++;
        if (words_loaded !== 9'd1) begin
            failures++;
            $display("FAIL restart_words: got %0d required 1", words_loaded);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_word(32'd2);
        send_word(32'hCAFEF00D);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h44;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0 || cpu_rst !== 1'b1 ||
            load_done !== 1'b0 || words_loaded !== '0 || bus.byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_rst: we=%b addr=%h data=%h cpu_rst=%b done=%b words=%0d ready=%b required reset values",
                     bus.imem_we, bus.imem_addr, bus.imem_wdata, cpu_rst, load_done, words_loaded, bus.byte_ready);
        end
        repeat (2) @(negedge clk);
        bus.byte_valid = 1'b0;
        rst = 1'b0;
        checks++;
        if (wr_addr.size() != 1) begin
            failures++;
            $display("FAIL async_no_write: got %0d writes required 1", wr_addr.size());
        end
        wr_addr.delete();
        wr_data.delete();
        @(negedge clk);
        send_word(32'd2);
        send_word(32'h12345678);
        send_word(32'h87654321);
        wait_done("async");
        checks++;
        if (wr_addr.size() != 2) begin
            failures++;
            $display("FAIL async_reload_count: got %0d writes required 2", wr_addr.size());
        end else if (wr_data[0] !== 32'h12345678 || wr_data[1] !== 32'h87654321 || wr_addr[1] !== 8'd1) begin
            failures++;
            $display("FAIL async_reload_data: d0=%h d1=%h a1=%h required 12345678/87654321/01",
                     wr_data[0], wr_data[1], wr_addr[1]);
        end
    endtask

    task automatic test_full_capacity();
        logic [7:0] v;
        do_reset();
        send_word(32'd256);
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            send_word({v, 8'h5A, ~v, v});
        end
        checks++;
        if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'hFF || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL full_last_pulse: we=%b addr=%h cpu_rst=%b required 1/ff/1",
                     bus.imem_we, bus.imem_addr, cpu_rst);
        end
        @(negedge clk);
        checks++;
        if (load_done !== 1'b1 || words_loaded !== 9'd256 || load_err !== 1'b0) begin
            failures++;
            $display("FAIL full_done: done=%b words=%0d err=%b required 1/256/0", load_done, words_loaded, load_err);
        end
        checks++;
        if (wr_addr.size() != 256) begin
            failures++;
            $display("FAIL full_count: got %0d writes required 256", wr_addr.size());
        end else if (wr_data[0] !== 32'h005AFF00 || wr_data[255] !== 32'hFF5A00FF || wr_addr[128] !== 8'h80) begin
            failures++;
            $display("FAIL full_data: d0=%h d255=%h a128=%h required 005aff00/ff5a00ff/80",
                     wr_data[0], wr_data[255], wr_addr[128]);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_header();
        test_overflow_header();
        test_random_valid();
        test_restart();
        test_async_reset();
        test_full_capacity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
